// File: rtl/pola_yolo_pkg.sv
// Shared types and default widths for the YOLO confidence-gate controller.
package pola_yolo_pkg;

  localparam int unsigned DEF_DELAY_CLOCK = 10;
  localparam int unsigned DEF_CONF_BIT    = 16;
  localparam int unsigned DEF_DIM_BIT     = 8;
  localparam int unsigned DEF_ANCHOR_BIT  = 2;
  localparam int unsigned DEF_CNT_BIT     = 16;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Tag layout at default widths; the controller builds the same layout at its own widths.
  typedef struct packed {
    logic                      keep;
    logic                      last;
    logic [DEF_DIM_BIT-1:0]    x;
    logic [DEF_DIM_BIT-1:0]    y;
    logic [DEF_ANCHOR_BIT-1:0] anchor;
  } tag_t;

endpackage

// File: rtl/pola_yolo_conf_gate_ctrl_if.sv
// Frame-config, confidence-stream and tag-output bundle of the confidence-gate controller.
// max_det exists only when POLA_YOLO_DET_CAP_EN is defined.
interface pola_yolo_conf_gate_ctrl_if #(
  parameter int unsigned CONF_BIT   = pola_yolo_pkg::DEF_CONF_BIT,
  parameter int unsigned DIM_BIT    = pola_yolo_pkg::DEF_DIM_BIT,
  parameter int unsigned ANCHOR_BIT = pola_yolo_pkg::DEF_ANCHOR_BIT,
  parameter int unsigned CNT_BIT    = pola_yolo_pkg::DEF_CNT_BIT
);
  logic                         start;
  logic [DIM_BIT-1:0]           grid_w;
  logic [DIM_BIT-1:0]           grid_h;
  logic [ANCHOR_BIT-1:0]        anchor_num;
  logic signed [CONF_BIT-1:0]   conf_threshold;
`ifdef POLA_YOLO_DET_CAP_EN
  logic [CNT_BIT-1:0]           max_det;
`endif
  logic                         in_valid;
  logic                         in_ready;
  logic signed [CONF_BIT-1:0]   in_conf;
  logic                         over_conf_threshold;
  logic                         out_valid;
  logic [DIM_BIT-1:0]           out_x;
  logic [DIM_BIT-1:0]           out_y;
  logic [ANCHOR_BIT-1:0]        out_anchor;
  logic                         out_last;
  logic                         busy;
  logic                         done;
  logic [CNT_BIT-1:0]           det_count;

  modport master (
`ifdef POLA_YOLO_DET_CAP_EN
    output max_det,
`endif
    output start, grid_w, grid_h, anchor_num, conf_threshold, in_valid, in_conf,
    input  in_ready, over_conf_threshold, out_valid, out_x, out_y, out_anchor, out_last,
    input  busy, done, det_count
  );

  modport slave (
`ifdef POLA_YOLO_DET_CAP_EN
    input  max_det,
`endif
    input  start, grid_w, grid_h, anchor_num, conf_threshold, in_valid, in_conf,
    output in_ready, over_conf_threshold, out_valid, out_x, out_y, out_anchor, out_last,
    output busy, done, det_count
  );

endinterface

// File: rtl/pola_yolo_tag_pipe.sv
// Fixed-depth tag shift register matching the latency of the confidence-gated delay lines.
module pola_yolo_tag_pipe #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned WIDTH = 20
) (
  input  logic             M_AXI_ACLK,
  input  logic             M_AXI_ARESETN,
  input  logic [WIDTH-1:0] tag_in,
  output logic [WIDTH-1:0] tag_out
);

  logic [DEPTH*WIDTH-1:0] sr_q;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[(DEPTH-1)*WIDTH-1:0], tag_in};
    end
  end

  assign tag_out = sr_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/pola_yolo_conf_gate_ctrl.sv
// Per-frame sequencer for the confidence-gated delay lines: scans boxes, gates on threshold,
// and emits coordinate tags aligned with the delay-line outputs. Option: POLA_YOLO_DET_CAP_EN.
module pola_yolo_conf_gate_ctrl
  import pola_yolo_pkg::*;
#(
  parameter int unsigned DELAY_CLOCK = DEF_DELAY_CLOCK,
  parameter int unsigned CONF_BIT    = DEF_CONF_BIT,
  parameter int unsigned DIM_BIT     = DEF_DIM_BIT,
  parameter int unsigned ANCHOR_BIT  = DEF_ANCHOR_BIT,
  parameter int unsigned CNT_BIT     = DEF_CNT_BIT
) (
  input logic                     M_AXI_ACLK,
  input logic                     M_AXI_ARESETN,
  pola_yolo_conf_gate_ctrl_if.slave bus
);

  localparam int unsigned DrainW = $clog2(DELAY_CLOCK);

  typedef struct packed {
    logic                  keep;
    logic                  last;
    logic [DIM_BIT-1:0]    x;
    logic [DIM_BIT-1:0]    y;
    logic [ANCHOR_BIT-1:0] anchor;
  } tag_w_t;

  state_e                     state_q, state_d;
  logic [DIM_BIT-1:0]         w_q, h_q, x_q, y_q;
  logic [ANCHOR_BIT-1:0]      anum_q, a_q;
  logic signed [CONF_BIT-1:0] thr_q;
  logic [CNT_BIT-1:0]         det_q;
  logic [DrainW-1:0]          drain_q;
  logic                       accept, keep, cap_hit, x_wrap, y_wrap, last_box, zero_cfg;
  logic                       drain_end;
  tag_w_t                     tag_in, tag_out;

`ifdef POLA_YOLO_DET_CAP_EN
  logic [CNT_BIT-1:0] max_q;
  // A zero cap leaves only the all-ones saturation in effect.
  assign cap_hit = (max_q != '0) && (det_q == max_q);
`else
  assign cap_hit = 1'b0;
`endif

  assign accept    = (state_q == StRun) && bus.in_valid;
  assign keep      = accept && (bus.in_conf > thr_q) && !cap_hit;
  assign x_wrap    = (x_q == w_q - DIM_BIT'(1));
  assign y_wrap    = (y_q == h_q - DIM_BIT'(1));
  assign last_box  = x_wrap && y_wrap && (a_q == anum_q - ANCHOR_BIT'(1));
  assign zero_cfg  = (bus.grid_w == '0) || (bus.grid_h == '0) || (bus.anchor_num == '0);
  assign drain_end = (drain_q == DrainW'(DELAY_CLOCK - 1));

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = zero_cfg ? StDone : StRun;
      StRun:   if (accept && last_box) state_d = StDrain;
      StDrain: if (drain_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == StRun);
    bus.busy     = (state_q == StRun) || (state_q == StDrain);
    bus.done     = (state_q == StDone);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      w_q     <= '0;
      h_q     <= '0;
      anum_q  <= '0;
      thr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      det_q   <= '0;
      drain_q <= '0;
`ifdef POLA_YOLO_DET_CAP_EN
      max_q   <= '0;
`endif
    end else begin
      if ((state_q == StIdle) && bus.start) begin
        w_q    <= bus.grid_w;
        h_q    <= bus.grid_h;
        anum_q <= bus.anchor_num;
        thr_q  <= bus.conf_threshold;
`ifdef POLA_YOLO_DET_CAP_EN
        max_q  <= bus.max_det;
`endif
        x_q    <= '0;
        y_q    <= '0;
        a_q    <= '0;
        det_q  <= '0;
      end else if (accept) begin
        if (x_wrap) begin
          x_q <= '0;
          if (y_wrap) begin
            y_q <= '0;
            a_q <= a_q + ANCHOR_BIT'(1);
          end else begin
            y_q <= y_q + DIM_BIT'(1);
          end
        end else begin
          x_q <= x_q + DIM_BIT'(1);
        end
        if (keep && (det_q != '1)) det_q <= det_q + CNT_BIT'(1);
      end
      drain_q <= (state_q == StDrain) ? drain_q + DrainW'(1) : '0;
    end
  end

  // Non-accept cycles push an all-zero tag so gaps read as empty at the outputs.
  always_comb begin
    tag_in = '0;
    if (accept) begin
      tag_in.keep   = keep;
      tag_in.last   = last_box;
      tag_in.x      = x_q;
      tag_in.y      = y_q;
      tag_in.anchor = a_q;
    end
  end

  pola_yolo_tag_pipe #(
    .DEPTH(DELAY_CLOCK),
    .WIDTH($bits(tag_w_t))
  ) u_tag_pipe (
    .M_AXI_ACLK   (M_AXI_ACLK),
    .M_AXI_ARESETN(M_AXI_ARESETN),
    .tag_in       (tag_in),
    .tag_out      (tag_out)
  );

  assign bus.over_conf_threshold = keep;
  assign bus.out_valid           = tag_out.keep;
  assign bus.out_last            = tag_out.last;
  assign bus.out_x               = tag_out.x;
  assign bus.out_y               = tag_out.y;
  assign bus.out_anchor          = tag_out.anchor;
  assign bus.det_count           = det_q;

endmodule

// File: tb/tb_pola_yolo_conf_gate_ctrl.sv
// Directed bench for pola_yolo_conf_gate_ctrl with a box-index reference model and
// per-cycle compare; the cap scenario runs only when POLA_YOLO_DET_CAP_EN is defined.
module tb_pola_yolo_conf_gate_ctrl;
  import pola_yolo_pkg::*;

  localparam int D    = DEF_DELAY_CLOCK;
  localparam int RING = 64;

  logic M_AXI_ACLK    = 1'b0;
  logic M_AXI_ARESETN = 1'b0;
  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  pola_yolo_conf_gate_ctrl_if bus ();

  pola_yolo_conf_gate_ctrl dut (
    .M_AXI_ACLK   (M_AXI_ACLK),
    .M_AXI_ARESETN(M_AXI_ARESETN),
    .bus          (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: frame described by box index k, coordinates derived arithmetically.
  tag_t              ring [RING];
  bit                m_ready = 0, m_busy = 0, m_done = 0;
  int                done_at = -1;
  int                m_w, m_h, m_an, m_k, m_total;
  logic signed [15:0] m_thr = '0;
  logic [15:0]       m_det = '0;
  logic [15:0]       m_max = '0;

  int last_seen = -1, done_seen = -1, valid_cnt = 0, done_cnt = 0;
  logic [17:0] obs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_capped();
`ifdef POLA_YOLO_DET_CAP_EN
    return (m_max != '0) && (m_det == m_max);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge M_AXI_ACLK) begin : model
    tag_t t;
    if (!M_AXI_ARESETN) begin
      for (int i = 0; i < RING; i++) ring[i] = '0;
      m_ready = 0; m_busy = 0; m_done = 0; m_det = '0; done_at = -1;
    end else begin
      if (m_ready && bus.in_valid) begin
        t.keep   = (bus.in_conf > m_thr) && !m_capped();
        t.last   = (m_k == m_total - 1);
        t.x      = 8'(m_k % m_w);
        t.y      = 8'((m_k / m_w) % m_h);
        t.anchor = 2'(m_k / (m_w * m_h));
        ring[(cyc + D) % RING] = t;
        if (t.keep && m_det != 16'hffff) m_det = m_det + 16'd1;
        m_k++;
        if (t.last) begin
          m_ready = 0;
          done_at = cyc + D + 1;
        end
      end
      if (!m_busy && !m_done && bus.start) begin
        m_w = int'(bus.grid_w); m_h = int'(bus.grid_h); m_an = int'(bus.anchor_num);
        m_thr = bus.conf_threshold;
`ifdef POLA_YOLO_DET_CAP_EN
        m_max = bus.max_det;
`endif
        m_det = '0;
        if (m_w == 0 || m_h == 0 || m_an == 0) begin
          done_at = cyc + 1;
        end else begin
          m_busy = 1; m_ready = 1; m_k = 0; m_total = m_w * m_h * m_an;
        end
      end
      m_done = (cyc + 1 == done_at);
      if (m_done) m_busy = 0;
    end
    cyc++;
  end

  always @(negedge M_AXI_ACLK) begin : cmp
    tag_t e;
    bit   exp_over;
    e = ring[cyc % RING];
    ring[cyc % RING] = '0;
    exp_over = m_ready && bus.in_valid && (bus.in_conf > m_thr) && !m_capped();
    chk("ctrl", {bus.in_ready, bus.busy, bus.done}, {m_ready, m_busy, m_done});
    chk("over", bus.over_conf_threshold, exp_over);
    chk("tag", {bus.out_valid, bus.out_last, bus.out_x, bus.out_y, bus.out_anchor}, e);
    chk("det", bus.det_count, m_det);
    if (bus.out_last === 1'b1) last_seen = cyc;
    if (bus.done === 1'b1) begin done_seen = cyc; done_cnt++; end
    if (bus.out_valid === 1'b1) begin
      valid_cnt++;
      obs.push_back({bus.out_x, bus.out_y, bus.out_anchor});
    end
  end

  task automatic tick();
    @(posedge M_AXI_ACLK);
    #1;
  endtask

  task automatic start_frame(input int w, input int h, input int an, input int thr);
    bus.grid_w = 8'(w); bus.grid_h = 8'(h); bus.anchor_num = 2'(an);
    bus.conf_threshold = 16'(thr);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 100) begin tick(); n++; end
    chk(name, 64'(n < 100), 64'd1);
    tick();
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.in_ready, bus.over_conf_threshold, bus.out_valid, bus.out_x, bus.out_y,
                bus.out_anchor, bus.out_last, bus.busy, bus.done, bus.det_count});
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int first_acc, acc, vcnt, dcnt;
    logic signed [15:0] c1 [4];
    bit                 o1 [4];
    logic [17:0]        exp2 [6];
    c1[0] = 16'sd50; c1[1] = 16'sd101; c1[2] = 16'sd100; c1[3] = -16'sd5;
    o1[0] = 0; o1[1] = 1; o1[2] = 0; o1[3] = 0;
    exp2[0] = {8'd0, 8'd0, 2'd0}; exp2[1] = {8'd1, 8'd0, 2'd0}; exp2[2] = {8'd2, 8'd0, 2'd0};
    exp2[3] = {8'd0, 8'd0, 2'd1}; exp2[4] = {8'd1, 8'd0, 2'd1}; exp2[5] = {8'd2, 8'd0, 2'd1};

    bus.start = 0; bus.grid_w = 0; bus.grid_h = 0; bus.anchor_num = 0;
    bus.conf_threshold = 0; bus.in_valid = 0; bus.in_conf = 0;
`ifdef POLA_YOLO_DET_CAP_EN
    bus.max_det = 0;
`endif
    repeat (3) tick();
    chk("rst_outputs", all_outs(), 64'd0);
    M_AXI_ARESETN = 1'b1;
    tick();

    // 2x2x1, thr=100: strict signed compare.
    obs.delete();
    start_frame(2, 2, 1, 100);
    first_acc = cyc;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_conf = c1[i];
      #1;
      chk("t1_over_lit", bus.over_conf_threshold, o1[i]);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_done("t1_done_seen");
    chk("t1_last_lat", 64'(last_seen - first_acc), 64'd13);
    chk("t1_done_lat", 64'(done_seen - first_acc), 64'd14);
    chk("t1_det_lit", bus.det_count, 64'd1);
    chk("t1_nvalid", 64'(obs.size()), 64'd1);
    if (obs.size() == 1) chk("t1_tag_lit", obs[0], {8'd1, 8'd0, 2'd0});

    // 3x1x2 with gapped valid.
    obs.delete();
    start_frame(3, 1, 2, -1000);
    acc = 0;
    for (int i = 0; i < 40 && acc < 6; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_conf  = bus.in_valid ? 16'(i * 10) : 16'sh7fff;
      if (bus.in_valid) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    wait_done("t2_done_seen");
    chk("t2_det_lit", bus.det_count, 64'd6);
    chk("t2_nvalid", 64'(obs.size()), 64'd6);
    if (obs.size() == 6)
      for (int i = 0; i < 6; i++) chk("t2_order_lit", obs[i], exp2[i]);

    // grid_h = 0: straight to DONE.
    start_frame(4, 0, 1, 0);
    chk("t3_done_lit", bus.done, 1'b1);
    chk("t3_ready_lit", bus.in_ready, 1'b0);
    chk("t3_det_lit", bus.det_count, 64'd0);
    tick();

    // Reset mid-frame with boxes in flight.
    start_frame(2, 2, 2, 0);
    bus.in_valid = 1'b1; bus.in_conf = 16'sd5;
    repeat (3) tick();
    M_AXI_ARESETN = 1'b0;
    tick();
    chk("t4_zero_lit", all_outs(), 64'd0);
    M_AXI_ARESETN = 1'b1; bus.in_valid = 1'b0;
    vcnt = valid_cnt; dcnt = done_cnt;
    repeat (20) tick();
    chk("t4_no_valid", 64'(valid_cnt), 64'(vcnt));
    chk("t4_no_done", 64'(done_cnt), 64'(dcnt));

    // start during RUN is ignored; original threshold stays.
    start_frame(2, 2, 1, 100);
    bus.in_valid = 1'b1; bus.in_conf = 16'sd50;
    tick();
    bus.in_conf = 16'sd150; bus.start = 1'b1; bus.conf_threshold = -16'sd100; bus.grid_h = 0;
    tick();
    bus.start = 1'b0; bus.in_conf = 16'sd50;
    tick();
    bus.in_conf = 16'sd150;
    tick();
    bus.in_valid = 1'b0;
    wait_done("t5_done_seen");
    chk("t5_det_lit", bus.det_count, 64'd2);

`ifdef POLA_YOLO_DET_CAP_EN
    obs.delete();
    bus.max_det = 16'd2;
    start_frame(2, 2, 1, 0);
    first_acc = cyc;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_conf = 16'((i + 1) * 10);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_done("t6_done_seen");
    chk("t6_det_lit", bus.det_count, 64'd2);
    chk("t6_nvalid", 64'(obs.size()), 64'd2);
    chk("t6_last_lat", 64'(last_seen - first_acc), 64'd13);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
